// File: rtl/pu_msp430_dbg_uart_pkg.sv
// pu_msp430_dbg_uart_pkg: shared types and constants for the debug UART transceiver.
// Holds the parity mode enum, the RX/TX state enums, the legal DATA_W range and
// helpers used by the transceiver top and its FIFOs.
package pu_msp430_dbg_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;
    localparam int IDX_W      = 4;

    function automatic bit data_w_legal(input int w);
        return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
    endfunction

    // The reserved mode behaves exactly like "none".
    function automatic bit parity_on(input parity_e p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/pu_msp430_dbg_uart_fifo.sv
// pu_msp430_dbg_uart_fifo: small synchronous FIFO with wrap-bit pointers.
// Ports: clk/rst_n (async active-low), push/push_data write side, pop/pop_data
// read side (pop_data shows the head), full/empty status. A pop on a full FIFO
// frees the slot so a same-cycle push is accepted.
module pu_msp430_dbg_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty    = wr_q == rd_q;
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        if (do_push) mem_d[wr_q[AW-1:0]] = push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pu_msp430_dbg_uart_xcvr.sv
// pu_msp430_dbg_uart_xcvr: debug-unit UART transceiver with RX/TX FIFOs.
// Ports: dbg_clk/dbg_rst_n (async active-low); cfg_div (bit = cfg_div+1 cycles),
// cfg_parity (0 none, 1 even, 2 odd, 3 none), cfg_stop2 (two TX stop bits);
// dbg_uart_rxd/dbg_uart_txd serial pins; tx_data/tx_valid/tx_ready TX push;
// rx_data/rx_perr/rx_ferr/rx_valid/rx_ready RX pop; rx_ovr drop pulse;
// tx_busy = serialiser active or TX FIFO non-empty.
module pu_msp430_dbg_uart_xcvr
    import pu_msp430_dbg_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic              dbg_clk,
    input  logic              dbg_rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              dbg_uart_rxd,
    output logic              dbg_uart_txd,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_perr,
    output logic              rx_ferr,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_ovr,
    output logic              tx_busy
);

    if (!data_w_legal(DATA_W) || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("pu_msp430_dbg_uart_xcvr: illegal DATA_W or FIFO_DEPTH");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic [1:0]  hist_q, hist_d;
    logic        filt_q, filt_d, rx_edge;

    rx_state_e         rx_st_q, rx_st_d;
    logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    parity_e           rx_pm_q, rx_pm_d;
    logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              rx_par_q, rx_par_d, rx_perr_q, rx_perr_d, rx_ovr_q, rx_ovr_d;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W+1:0] rx_head;

    tx_state_e         tx_st_q, tx_st_d;
    logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    parity_e           tx_pm_q, tx_pm_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, tx_head;
    logic              tx_par_q, tx_par_d, tx_stop2_q, tx_stop2_d, txd_q, txd_d;
    logic              tx_push, tx_pop, tx_load, tx_full, tx_empty;

    // Filter output only moves when the pin and both history flops agree.
    always_comb begin
        hist_d = {hist_q[0], dbg_uart_rxd};
        filt_d = (&{dbg_uart_rxd, hist_q}) ? 1'b1 : (~|{dbg_uart_rxd, hist_q}) ? 1'b0 : filt_q;
    end

    assign rx_edge = filt_d != filt_q;

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = (rx_st_q == RX_IDLE) ? rx_cnt_q : rx_cnt_q - 1'b1;
        rx_div_d  = rx_div_q;
        rx_pm_d   = rx_pm_q;
        rx_idx_d  = rx_idx_q;
        rx_sh_d   = rx_sh_q;
        rx_par_d  = rx_par_q;
        rx_perr_d = rx_perr_q;
        rx_push   = 1'b0;
        case (rx_st_q)
            RX_IDLE: if (filt_q & ~filt_d) begin
                rx_st_d   = RX_START;
                rx_cnt_d  = cfg_div >> 1;
                rx_div_d  = cfg_div;
                rx_pm_d   = parity_e'(cfg_parity);
                rx_idx_d  = '0;
                rx_par_d  = 1'b0;
                rx_perr_d = 1'b0;
            end
            RX_START: if (rx_cnt_q == '0) begin
                rx_cnt_d = rx_div_q;
                rx_st_d  = filt_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d = rx_div_q;
                rx_sh_d  = {filt_q, rx_sh_q[DATA_W-1:1]};
                rx_par_d = rx_par_q ^ filt_q;
                rx_idx_d = rx_idx_q + 1'b1;
                if (rx_idx_q == LAST_IDX) rx_st_d = parity_on(rx_pm_q) ? RX_PARITY : RX_STOP;
            end else if (rx_edge) begin
                rx_cnt_d = rx_div_q >> 1;
            end
            RX_PARITY: if (rx_cnt_q == '0) begin
                rx_cnt_d  = rx_div_q;
                rx_perr_d = rx_par_q ^ filt_q ^ (rx_pm_q == PAR_ODD);
                rx_st_d   = RX_STOP;
            end else if (rx_edge) begin
                rx_cnt_d = rx_div_q >> 1;
            end
            RX_STOP: if (rx_cnt_q == '0) begin
                rx_push = 1'b1;
                rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    assign rx_pop   = rx_valid & rx_ready;
    assign rx_valid = ~rx_empty;
    assign rx_ovr_d = rx_push & rx_full & ~rx_pop;
    assign {rx_ferr, rx_perr, rx_data} = rx_head;
    assign rx_ovr   = rx_ovr_q;

    pu_msp430_dbg_uart_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (dbg_clk),
        .rst_n     (dbg_rst_n),
        .push      (rx_push),
        .push_data ({~filt_q, rx_perr_q, rx_sh_q}),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = (tx_st_q == TX_IDLE) ? tx_cnt_q : tx_cnt_q - 1'b1;
        tx_div_d   = tx_div_q;
        tx_pm_d    = tx_pm_q;
        tx_stop2_d = tx_stop2_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        case (tx_st_q)
            TX_IDLE: tx_load = ~tx_empty;
            TX_START: if (tx_cnt_q == '0) begin
                tx_st_d  = TX_DATA;
                tx_cnt_d = tx_div_q;
                tx_idx_d = '0;
                txd_d    = tx_sh_q[0];
            end
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = tx_div_q;
                tx_sh_d  = tx_sh_q >> 1;
                tx_idx_d = tx_idx_q + 1'b1;
                txd_d    = tx_sh_q[1];
                if (tx_idx_q == LAST_IDX) begin
                    tx_idx_d = '0;
                    tx_st_d  = parity_on(tx_pm_q) ? TX_PARITY : TX_STOP;
                    txd_d    = parity_on(tx_pm_q) ? tx_par_q ^ (tx_pm_q == PAR_ODD) : 1'b1;
                end
            end
            TX_PARITY: if (tx_cnt_q == '0) begin
                tx_cnt_d = tx_div_q;
                tx_st_d  = TX_STOP;
                txd_d    = 1'b1;
            end
            TX_STOP: if (tx_cnt_q == '0) begin
                if (tx_stop2_q && tx_idx_q == '0) begin
                    tx_idx_d = IDX_W'(1);
                    tx_cnt_d = tx_div_q;
                end else if (!tx_empty) begin
                    tx_load = 1'b1;
                end else begin
                    tx_st_d = TX_IDLE;
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
        // Loading from IDLE or straight out of the last stop bit gives back-to-back frames.
        if (tx_load) begin
            tx_st_d    = TX_START;
            tx_cnt_d   = cfg_div;
            tx_div_d   = cfg_div;
            tx_pm_d    = parity_e'(cfg_parity);
            tx_stop2_d = cfg_stop2;
            tx_sh_d    = tx_head;
            tx_par_d   = ^tx_head;
            txd_d      = 1'b0;
        end
    end

    assign tx_pop       = tx_load;
    assign tx_ready     = ~tx_full;
    assign tx_push      = tx_valid & tx_ready;
    assign tx_busy      = (tx_st_q != TX_IDLE) | ~tx_empty;
    assign dbg_uart_txd = txd_q;

    pu_msp430_dbg_uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (dbg_clk),
        .rst_n     (dbg_rst_n),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
        if (!dbg_rst_n) begin
            hist_q     <= 2'b11;
            filt_q     <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_pm_q    <= PAR_NONE;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_st_q    <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_pm_q    <= PAR_NONE;
            tx_stop2_q <= 1'b0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            hist_q     <= hist_d;
            filt_q     <= filt_d;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_pm_q    <= rx_pm_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_pm_q    <= tx_pm_d;
            tx_stop2_q <= tx_stop2_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: tb/tb_pu_msp430_dbg_uart_xcvr.sv
// tb_pu_msp430_dbg_uart_xcvr: directed self-checking bench for the debug UART transceiver.
module tb_pu_msp430_dbg_uart_xcvr;

    logic        dbg_clk = 1'b0;
    logic        dbg_rst_n = 1'b0;
    logic [15:0] cfg_div = 16'd9;
    logic [1:0]  cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0;
    logic        dbg_uart_rxd = 1'b1;
    logic        dbg_uart_txd;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_ovr, tx_busy;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;

    pu_msp430_dbg_uart_xcvr #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .dbg_clk      (dbg_clk),
        .dbg_rst_n    (dbg_rst_n),
        .cfg_div      (cfg_div),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .dbg_uart_rxd (dbg_uart_rxd),
        .dbg_uart_txd (dbg_uart_txd),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_perr      (rx_perr),
        .rx_ferr      (rx_ferr),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_ovr       (rx_ovr),
        .tx_busy      (tx_busy)
    );

    always #5 dbg_clk = ~dbg_clk;

    always @(negedge dbg_clk) if (rx_ovr === 1'b1) ovr_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_bit(input logic v);
        dbg_uart_rxd = v;
        repeat (int'(cfg_div) + 1) @(posedge dbg_clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit use_par, input logic par_bit, input logic stop_bit);
        @(posedge dbg_clk);
        #1;
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        if (use_par) rx_bit(par_bit);
        rx_bit(stop_bit);
        dbg_uart_rxd = 1'b1;
    endtask

    // Budget of 8 cycles after the frame ends keeps total latency within 10 bit-times + 8.
    task automatic wait_rx(input string tag);
        int n = 0;
        while (rx_valid !== 1'b1 && n < 8) begin
            @(negedge dbg_clk);
            n++;
        end
        chk(tag, rx_valid, 1);
    endtask

    task automatic rx_pop(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        @(negedge dbg_clk);
        chk($sformatf("%s_valid", tag), rx_valid, 1);
        chk($sformatf("%s_data", tag), rx_data, d);
        chk($sformatf("%s_perr", tag), rx_perr, pe);
        chk($sformatf("%s_ferr", tag), rx_ferr, fe);
        rx_ready = 1'b1;
        @(negedge dbg_clk);
        rx_ready = 1'b0;
    endtask

    logic [11:0] frame;
    logic [7:0]  burst [3];
    int          s;
    int          ovr_base;

    initial begin
        burst[0] = 8'h11;
        burst[1] = 8'h22;
        burst[2] = 8'h33;

        #12;
        chk("rst_txd", dbg_uart_txd, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_perr", rx_perr, 0);
        chk("rst_rx_ferr", rx_ferr, 0);
        chk("rst_rx_ovr", rx_ovr, 0);
        chk("rst_tx_busy", tx_busy, 0);
        @(negedge dbg_clk);
        dbg_rst_n = 1'b1;
        repeat (5) @(negedge dbg_clk);

        rx_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_rx("8n1_latency");
        rx_pop("8n1", 8'hA5, 1'b0, 1'b0);
        chk("8n1_empty", rx_valid, 0);
        repeat (20) @(negedge dbg_clk);

        cfg_parity = 2'd1;
        rx_frame(8'h03, 1'b1, 1'b1, 1'b1);
        wait_rx("even_bad_latency");
        rx_pop("even_bad", 8'h03, 1'b1, 1'b0);
        repeat (20) @(negedge dbg_clk);
        rx_frame(8'h03, 1'b1, 1'b0, 1'b1);
        wait_rx("even_ok_latency");
        rx_pop("even_ok", 8'h03, 1'b0, 1'b0);
        repeat (20) @(negedge dbg_clk);

        cfg_parity = 2'd0;
        rx_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        wait_rx("stop_low_latency");
        rx_pop("stop_low", 8'h5A, 1'b0, 1'b1);
        repeat (20) @(negedge dbg_clk);
        rx_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_rx("resync_latency");
        rx_pop("resync", 8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge dbg_clk);

        ovr_base = ovr_cnt;
        for (int k = 1; k <= 5; k++) begin
            rx_frame(8'(k), 1'b0, 1'b0, 1'b1);
            repeat (20) @(negedge dbg_clk);
        end
        chk("ovr_pulses", ovr_cnt - ovr_base, 1);
        for (int k = 1; k <= 4; k++) rx_pop($sformatf("ovr_pop%0d", k), 8'(k), 1'b0, 1'b0);
        chk("ovr_fifth_dropped", rx_valid, 0);
        repeat (10) @(negedge dbg_clk);

        @(negedge dbg_clk);
        dbg_uart_rxd = 1'b0;
        @(negedge dbg_clk);
        dbg_uart_rxd = 1'b1;
        repeat (150) @(negedge dbg_clk);
        chk("glitch_no_rx", rx_valid, 0);
        chk("glitch_no_ovr", ovr_cnt - ovr_base, 1);

        cfg_div = 16'd3;
        cfg_parity = 2'd2;
        cfg_stop2 = 1'b1;
        s = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge dbg_clk);
            if (i < 3) begin
                chk($sformatf("burst_ready%0d", i), tx_ready, 1);
                tx_valid = 1'b1;
                tx_data = burst[i];
            end else begin
                tx_valid = 1'b0;
            end
            if (s < 0 && dbg_uart_txd === 1'b0) s = i;
            if (s >= 0 && i - s < 144) begin
                frame = {2'b11, ~^burst[(i - s) / 48], burst[(i - s) / 48], 1'b0};
                chk($sformatf("burst_txd_c%0d", i - s), dbg_uart_txd, frame[((i - s) % 48) / 4]);
                chk($sformatf("burst_busy_c%0d", i - s), tx_busy, 1);
            end
            if (s >= 0 && i - s == 144) begin
                chk("burst_end_txd", dbg_uart_txd, 1);
                chk("burst_end_busy", tx_busy, 0);
                break;
            end
        end
        chk("burst_started", s >= 0, 1);
        repeat (10) @(negedge dbg_clk);

        tx_valid = 1'b1;
        tx_data = 8'h00;
        @(negedge dbg_clk);
        tx_valid = 1'b0;
        repeat (12) @(negedge dbg_clk);
        chk("midtx_busy", tx_busy, 1);
        #3;
        dbg_rst_n = 1'b0;
        #1;
        chk("midtx_rst_txd", dbg_uart_txd, 1);
        chk("midtx_rst_ready", tx_ready, 1);
        chk("midtx_rst_busy", tx_busy, 0);
        repeat (2) @(negedge dbg_clk);
        dbg_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge dbg_clk);
            chk($sformatf("post_rst_txd%0d", i), dbg_uart_txd, 1);
        end
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_rx_valid", rx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
